mem_io_responder: RTL and testbench

- Memory-side responder for the CPU's byte-wide memory bus (address, write strobe, 8-bit data each way, io_buffer_full back-pressure).
- Decodes each CPU access to external synchronous RAM or to the memory-mapped I/O window (addr[17:16]==2'b11).
- Owns the UART TX FIFO, RX pop, cycle counter and program-stop logic.
- Sits at the chip top between the CPU core, the RAM macro and the UART.

---
 rtl/mem_io_pkg.sv | 19 +
 rtl/mem_io_responder_if.sv | 37 +++
 rtl/io_tx_fifo.sv | 60 ++++++
 rtl/mem_io_responder.sv | 120 ++++++++++++
 tb/tb_mem_io_responder.sv | 372 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_io_pkg.sv
// Shared constants and types for the memory/I-O responder: I/O window decode,
// read-source select and TX FIFO entry layout.
package mem_io_pkg;

  localparam logic [1:0]  IO_SEL       = 2'b11;
  localparam logic [17:0] IO_UART_ADDR = 18'h30000;
  localparam logic [17:0] IO_CNT_ADDR  = 18'h30004;

  typedef enum logic {
    RSEL_RAM,
    RSEL_IO
  } rsel_e;

  typedef struct packed {
    logic       stop;
    logic [7:0] data;
  } tx_entry_t;

endpackage

// File: rtl/mem_io_responder_if.sv
// CPU byte bus plus the RAM and UART sides of the responder, bundled as one interface.
// The master modport is the environment (CPU, RAM macro, UART); slave is the responder.
interface mem_io_responder_if #(
  parameter int unsigned RAM_AW = 17
);

  logic [31:0]       cpu_a;
  logic              cpu_wr;
  logic [7:0]        cpu_wdata;
  logic [7:0]        cpu_rdata;
  logic              io_buffer_full;
  logic [RAM_AW-1:0] ram_addr;
  logic              ram_we;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_rdata;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              program_stop;
  logic              tx_overflow;

  modport master (
    output cpu_a, cpu_wr, cpu_wdata, ram_rdata, tx_ready, rx_data, rx_valid,
    input  cpu_rdata, io_buffer_full, ram_addr, ram_we, ram_wdata, tx_data, tx_valid,
           rx_ready, program_stop, tx_overflow
  );

  modport slave (
    input  cpu_a, cpu_wr, cpu_wdata, ram_rdata, tx_ready, rx_data, rx_valid,
    output cpu_rdata, io_buffer_full, ram_addr, ram_we, ram_wdata, tx_data, tx_valid,
           rx_ready, program_stop, tx_overflow
  );

endinterface

// File: rtl/io_tx_fifo.sv
// Synchronous FIFO of TX entries with simultaneous push/pop and a next-state count.
// A push while full is dropped unless a pop happens on the same edge.
module io_tx_fifo
  import mem_io_pkg::*;
#(
  parameter int unsigned Depth = 8,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            push_i,
  input  tx_entry_t       data_i,
  input  logic            pop_i,
  output tx_entry_t       data_o,
  output logic            empty_o,
  output logic            full_o,
  output logic [CntW-1:0] count_d_o
);

  tx_entry_t       mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(Depth));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  assign count_d_o = count_d;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk_in) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/mem_io_responder.sv
// Memory-side responder: decodes CPU byte accesses to RAM or the I/O window and owns
// the UART TX FIFO, RX pop, free-running cycle counter and program-stop logic.
module mem_io_responder
  import mem_io_pkg::*;
#(
  parameter int unsigned RAM_AW      = 17,
  parameter int unsigned TX_DEPTH    = 8,
  parameter int unsigned FULL_MARGIN = 2
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  mem_io_responder_if.slave  bus
);

  localparam int unsigned CntW = $clog2(TX_DEPTH) + 1;
  localparam logic [CntW-1:0] FullThresh = CntW'(TX_DEPTH - FULL_MARGIN);

  logic [17:0] addr;
  logic        is_io, rd_acc, wr_io;
  logic        is_uart, is_cnt;

  rsel_e       rsel_q;
  logic [7:0]  io_q, io_rd;
  logic [31:0] cnt_q, snap_q;
  logic        stop_seen_q, program_stop_q, tx_overflow_q, io_buffer_full_q;

  logic        push, pop, fifo_empty, fifo_full;
  tx_entry_t   push_entry, head;
  logic [CntW-1:0] count_d;

  logic unused_bits;
  assign unused_bits = ^{bus.cpu_a[31:18], snap_q[7:0]};

  assign addr    = bus.cpu_a[17:0];
  assign is_io   = (addr[17:16] == IO_SEL);
  assign is_uart = (addr == IO_UART_ADDR);
  assign is_cnt  = (addr == IO_CNT_ADDR);
  assign rd_acc  = rdy_in & ~bus.cpu_wr & ~rst_in;
  assign wr_io   = rdy_in & bus.cpu_wr & is_io & ~stop_seen_q & ~rst_in;

  assign bus.ram_addr  = bus.cpu_a[RAM_AW-1:0];
  assign bus.ram_wdata = bus.cpu_wdata;
  assign bus.ram_we    = rdy_in & bus.cpu_wr & ~is_io & ~rst_in;

  assign bus.rx_ready  = rd_acc & is_uart & bus.rx_valid;

  // Upper counter bytes come from the snapshot so a 4-byte read stays coherent.
  always_comb begin
    io_rd = 8'h00;
    case (addr)
      IO_UART_ADDR:         io_rd = bus.rx_valid ? bus.rx_data : 8'h00;
      IO_CNT_ADDR:          io_rd = cnt_q[7:0];
      IO_CNT_ADDR + 18'd1:  io_rd = snap_q[15:8];
      IO_CNT_ADDR + 18'd2:  io_rd = snap_q[23:16];
      IO_CNT_ADDR + 18'd3:  io_rd = snap_q[31:24];
      default:              io_rd = 8'h00;
    endcase
  end

  always_comb begin
    push       = 1'b0;
    push_entry = '{stop: 1'b0, data: bus.cpu_wdata};
    if (wr_io && is_uart && (bus.cpu_wdata != 8'h00)) begin
      push = 1'b1;
    end else if (wr_io && is_cnt) begin
      push       = 1'b1;
      push_entry = '{stop: 1'b1, data: 8'h00};
    end
  end

  assign bus.tx_valid = ~fifo_empty & ~rst_in;
  assign bus.tx_data  = head.data;
  assign pop          = bus.tx_valid & bus.tx_ready;

  io_tx_fifo #(
    .Depth (TX_DEPTH)
  ) u_tx_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push_i    (push),
    .data_i    (push_entry),
    .pop_i     (pop),
    .data_o    (head),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full),
    .count_d_o (count_d)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_q            <= '0;
      snap_q           <= '0;
      rsel_q           <= RSEL_RAM;
      io_q             <= 8'h00;
      stop_seen_q      <= 1'b0;
      program_stop_q   <= 1'b0;
      tx_overflow_q    <= 1'b0;
      io_buffer_full_q <= 1'b0;
    end else begin
      if (rdy_in) cnt_q <= cnt_q + 32'd1;
      if (rd_acc) begin
        rsel_q <= is_io ? RSEL_IO : RSEL_RAM;
        if (is_io) io_q <= io_rd;
        if (is_cnt) snap_q <= cnt_q;
      end
      if (wr_io && is_cnt) stop_seen_q <= 1'b1;
      if (push && fifo_full && !pop) tx_overflow_q <= 1'b1;
      if (pop && head.stop) program_stop_q <= 1'b1;
      io_buffer_full_q <= (count_d >= FullThresh);
    end
  end

  // Reset forces the read path to zero even though rsel resets to RAM.
  assign bus.cpu_rdata      = rst_in ? 8'h00 : ((rsel_q == RSEL_RAM) ? bus.ram_rdata : io_q);
  assign bus.io_buffer_full = io_buffer_full_q;
  assign bus.program_stop   = program_stop_q;
  assign bus.tx_overflow    = tx_overflow_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed self-checking bench for mem_io_responder with a behavioural RAM and a TX capture.
module tb_mem_io_responder;

  localparam logic [17:0] UART = 18'h30000;
  localparam logic [17:0] CNT  = 18'h30004;

  logic clk = 1'b0;
  logic rst, rdy;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] ram_mem [0:131071];
  logic [7:0] txq [$];

  mem_io_responder_if #(.RAM_AW(17)) bus ();

  mem_io_responder #(
    .RAM_AW      (17),
    .TX_DEPTH    (8),
    .FULL_MARGIN (2)
  ) dut (
    .clk_in (clk),
    .rst_in (rst),
    .rdy_in (rdy),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= ram_mem[bus.ram_addr];
  end

  always @(posedge clk) begin
    if (bus.tx_valid && bus.tx_ready) txq.push_back(bus.tx_data);
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    bus.cpu_wr = 1'b0;
    bus.cpu_a  = 32'h0;
  endtask

  task automatic wr(input logic [17:0] a, input logic [7:0] d);
    bus.cpu_a     = {14'h0, a};
    bus.cpu_wr    = 1'b1;
    bus.cpu_wdata = d;
  endtask

  task automatic rd(input logic [17:0] a);
    bus.cpu_a  = {14'h0, a};
    bus.cpu_wr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h99;
    rd(18'h00020);
    step(2);
    checks++;
    if (bus.cpu_rdata !== 8'h00) begin
      errors++; $display("FAIL reset_rdata: got %h expected 00", bus.cpu_rdata);
    end
    checks++;
    if ({bus.tx_valid, bus.io_buffer_full, bus.program_stop, bus.tx_overflow} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000",
               {bus.tx_valid, bus.io_buffer_full, bus.program_stop, bus.tx_overflow});
    end
    wr(18'h00020, 8'h77);
    #1;
    checks++;
    if (bus.ram_we !== 1'b0) begin
      errors++; $display("FAIL reset_ram_we: got %b expected 0", bus.ram_we);
    end
    rd(UART);
    #1;
    checks++;
    if (bus.rx_ready !== 1'b0) begin
      errors++; $display("FAIL reset_rx_ready: got %b expected 0", bus.rx_ready);
    end
    step();
    rst = 1'b0;
    bus.rx_valid = 1'b0;
    idle();
    step();
    rd(18'h00020);
    step();
    checks++;
    if (bus.cpu_rdata !== 8'h5C) begin
      errors++; $display("FAIL reset_no_ram_write: got %h expected 5c", bus.cpu_rdata);
    end
  endtask

  task automatic test_ram();
    wr(18'h00010, 8'hA5);
    #1;
    checks++;
    if (bus.ram_we !== 1'b1) begin
      errors++; $display("FAIL ram_we_on_write: got %b expected 1", bus.ram_we);
    end
    step();
    rd(18'h00010);
    #1;
    checks++;
    if (bus.ram_we !== 1'b0) begin
      errors++; $display("FAIL ram_we_on_read: got %b expected 0", bus.ram_we);
    end
    step();
    idle();
    checks++;
    if (bus.cpu_rdata !== 8'hA5) begin
      errors++; $display("FAIL ram_readback: got %h expected a5", bus.cpu_rdata);
    end
  endtask

  task automatic test_uart();
    bus.tx_ready = 1'b1;
    txq.delete();
    wr(UART, 8'h48); step();
    wr(UART, 8'h00); step();
    wr(UART, 8'h69); step();
    idle(); step(4);
    checks++;
    if (txq.size() != 2 || txq[0] !== 8'h48 || txq[1] !== 8'h69) begin
      errors++;
      $display("FAIL uart_stream: got %0d bytes first %h second %h expected 2 bytes 48 69",
               txq.size(), (txq.size() > 0) ? txq[0] : 8'hxx, (txq.size() > 1) ? txq[1] : 8'hxx);
    end
    bus.tx_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      wr(UART, 8'(8'h10 + i));
      step();
      if (i == 5) begin
        checks++;
        if (bus.io_buffer_full !== 1'b0) begin
          errors++; $display("FAIL uart_full_after5: got %b expected 0", bus.io_buffer_full);
        end
      end
    end
    idle();
    checks++;
    if (bus.io_buffer_full !== 1'b1) begin
      errors++; $display("FAIL uart_full_after6: got %b expected 1", bus.io_buffer_full);
    end
    bus.tx_ready = 1'b1;
    step(10);
    checks++;
    if (bus.io_buffer_full !== 1'b0 || txq.size() != 8) begin
      errors++;
      $display("FAIL uart_drain: got full %b count %0d expected full 0 count 8",
               bus.io_buffer_full, txq.size());
    end
  endtask

  task automatic test_overflow();
    bus.tx_ready = 1'b0;
    txq.delete();
    for (int i = 1; i <= 8; i++) begin
      wr(UART, 8'(i));
      step();
    end
    checks++;
    if (bus.tx_overflow !== 1'b0 || bus.tx_data !== 8'h01) begin
      errors++;
      $display("FAIL ovf_full8: got ovf %b head %h expected ovf 0 head 01",
               bus.tx_overflow, bus.tx_data);
    end
    bus.tx_ready = 1'b1;
    wr(UART, 8'h0A);
    step();
    idle();
    checks++;
    if (bus.tx_overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_push_pop_full: got %b expected 0", bus.tx_overflow);
    end
    step(12);
    checks++;
    if (txq.size() != 9 || txq[8] !== 8'h0A || txq[0] !== 8'h01 || txq[7] !== 8'h08) begin
      errors++;
      $display("FAIL ovf_push_pop_stream: got %0d bytes last %h expected 9 bytes last 0a",
               txq.size(), (txq.size() > 0) ? txq[txq.size()-1] : 8'hxx);
    end
    bus.tx_ready = 1'b0;
    txq.delete();
    for (int i = 1; i <= 9; i++) begin
      wr(UART, 8'(8'h20 + i));
      step();
    end
    idle();
    checks++;
    if (bus.tx_overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_sticky: got %b expected 1", bus.tx_overflow);
    end
    bus.tx_ready = 1'b1;
    step(12);
    checks++;
    if (txq.size() != 8 || txq[7] !== 8'h28) begin
      errors++;
      $display("FAIL ovf_dropped: got %0d bytes last %h expected 8 bytes last 28",
               txq.size(), (txq.size() > 0) ? txq[txq.size()-1] : 8'hxx);
    end
  endtask

  task automatic test_counter();
    rst = 1'b1;
    idle();
    step();
    rst = 1'b0;
    step(9'h1FF);
    rd(CNT);            step(); rd(CNT + 18'd1);
    checks++;
    if (bus.cpu_rdata !== 8'hFF) begin
      errors++; $display("FAIL cnt_byte0: got %h expected ff", bus.cpu_rdata);
    end
    step(); rd(CNT + 18'd2);
    checks++;
    if (bus.cpu_rdata !== 8'h01) begin
      errors++; $display("FAIL cnt_byte1: got %h expected 01", bus.cpu_rdata);
    end
    step(); rd(CNT + 18'd3);
    checks++;
    if (bus.cpu_rdata !== 8'h00) begin
      errors++; $display("FAIL cnt_byte2: got %h expected 00", bus.cpu_rdata);
    end
    step();
    checks++;
    if (bus.cpu_rdata !== 8'h00) begin
      errors++; $display("FAIL cnt_byte3: got %h expected 00", bus.cpu_rdata);
    end
    rdy = 1'b0;
    rd(CNT);
    step(10);
    checks++;
    if (bus.cpu_rdata !== 8'h00) begin
      errors++; $display("FAIL cnt_rdy_hold_rdata: got %h expected 00", bus.cpu_rdata);
    end
    rdy = 1'b1;
    step(); rd(CNT + 18'd1);
    checks++;
    if (bus.cpu_rdata !== 8'h03) begin
      errors++; $display("FAIL cnt_frozen_byte0: got %h expected 03", bus.cpu_rdata);
    end
    step();
    idle();
    checks++;
    if (bus.cpu_rdata !== 8'h02) begin
      errors++; $display("FAIL cnt_frozen_byte1: got %h expected 02", bus.cpu_rdata);
    end
  endtask

  task automatic test_stop();
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.tx_ready = 1'b1;
    txq.delete();
    wr(UART, 8'h41); step();
    wr(CNT, 8'h00);  step();
    wr(UART, 8'h42);
    checks++;
    if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h00 || bus.program_stop !== 1'b0) begin
      errors++;
      $display("FAIL stop_before: got valid %b data %h stop %b expected 1 00 0",
               bus.tx_valid, bus.tx_data, bus.program_stop);
    end
    step();
    idle();
    checks++;
    if (bus.program_stop !== 1'b1 || bus.tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL stop_rise: got stop %b valid %b expected 1 0",
               bus.program_stop, bus.tx_valid);
    end
    step(5);
    checks++;
    if (txq.size() != 2 || txq[0] !== 8'h41 || txq[1] !== 8'h00 || bus.program_stop !== 1'b1) begin
      errors++;
      $display("FAIL stop_stream: got %0d bytes stop %b expected 2 bytes 41 00 stop 1",
               txq.size(), bus.program_stop);
    end
  endtask

  task automatic test_rx_reset();
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h37;
    rd(UART);
    #1;
    checks++;
    if (bus.rx_ready !== 1'b1) begin
      errors++; $display("FAIL rx_ready_pulse: got %b expected 1", bus.rx_ready);
    end
    step();
    idle();
    #1;
    checks++;
    if (bus.cpu_rdata !== 8'h37 || bus.rx_ready !== 1'b0) begin
      errors++;
      $display("FAIL rx_data: got %h ready %b expected 37 ready 0", bus.cpu_rdata, bus.rx_ready);
    end
    bus.rx_valid = 1'b0;
    rd(UART);
    step();
    idle();
    checks++;
    if (bus.cpu_rdata !== 8'h00) begin
      errors++; $display("FAIL rx_empty: got %h expected 00", bus.cpu_rdata);
    end
    // program_stop is still set from the stop scenario
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (bus.program_stop !== 1'b0) begin
      errors++; $display("FAIL rst_program_stop: got %b expected 0", bus.program_stop);
    end
    bus.tx_ready = 1'b0;
    wr(UART, 8'h51); step();
    wr(UART, 8'h52); step();
    wr(UART, 8'h53); step();
    idle();
    txq.delete();
    bus.tx_ready = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    rd(CNT);
    checks++;
    if (bus.tx_valid !== 1'b0 || txq.size() != 0) begin
      errors++;
      $display("FAIL rst_fifo_flush: got valid %b popped %0d expected 0 0",
               bus.tx_valid, txq.size());
    end
    step();
    idle();
    checks++;
    if (bus.cpu_rdata !== 8'h00) begin
      errors++; $display("FAIL rst_cnt_zero: got %h expected 00", bus.cpu_rdata);
    end
  endtask

  initial begin
    for (int i = 0; i < 131072; i++) ram_mem[i] = 8'h00;
    ram_mem[32'h20] = 8'h5C;
    rst = 1'b1;
    rdy = 1'b1;
    bus.cpu_a     = 32'h0;
    bus.cpu_wr    = 1'b0;
    bus.cpu_wdata = 8'h00;
    bus.tx_ready  = 1'b0;
    bus.rx_data   = 8'h00;
    bus.rx_valid  = 1'b0;
    test_reset();
    test_ram();
    test_uart();
    test_overflow();
    test_counter();
    test_stop();
    test_rx_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
